// File: rtl/pdm_rx.sv
// pdm_rx: PDM bitstream receiver. Synchronizes the raw bit, runs a 3rd-order
// CIC decimator (R = 2**DECIM_LOG2) with modular arithmetic, clamps the single
// full-scale overflow value and emits the top WIDTH bits once per frame.
module pdm_rx #(
  parameter int DECIM_LOG2 = 6,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_in,
  input  logic             pdm_stb,
  output logic [WIDTH-1:0] out_val,
  output logic             out_stb
);

  localparam int N     = 3 * DECIM_LOG2 + 1;
  localparam int SHIFT = N - 1 - WIDTH;
  localparam logic [DECIM_LOG2-1:0] CNT_MAX = {DECIM_LOG2{1'b1}};
  localparam logic [DECIM_LOG2-1:0] CNT_ONE = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

  logic                  s0_r;
  logic                  s1_r;
  logic [N-1:0]          x_s;
  logic [N-1:0]          i1_r, i2_r, i3_r;
  logic [N-1:0]          i1_s, i2_s, i3_s;
  logic [DECIM_LOG2-1:0] cnt_r;
  logic                  dec_r;
  logic [N-1:0]          d1_r, d2_r, d3_r;
  logic [N-1:0]          c1_s, c2_s, c3_s;
  logic [N-2:0]          sat_s;
  logic [WIDTH-1:0]      word_s;

  // Two-flop synchronizer for the asynchronous PDM pad bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_r <= 1'b0;
      s1_r <= 1'b0;
    end else begin
      s0_r <= pdm_in;
      s1_r <= s0_r;
    end
  end

  // Cascaded integrator sums: each stage adds the freshly updated previous stage.
  always_comb begin
    x_s  = {{(N-1){1'b0}}, s1_r};
    i1_s = i1_r + x_s;
    i2_s = i2_r + i1_s;
    i3_s = i3_r + i2_s;
  end

  // Integrator registers and decimation counter advance only on a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_r  <= {N{1'b0}};
      i2_r  <= {N{1'b0}};
      i3_r  <= {N{1'b0}};
      cnt_r <= {DECIM_LOG2{1'b0}};
    end else if (pdm_stb) begin
      i1_r  <= i1_s;
      i2_r  <= i2_s;
      i3_r  <= i3_s;
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      i1_r  <= i1_r;
      i2_r  <= i2_r;
      i3_r  <= i3_r;
      cnt_r <= cnt_r;
    end
  end

  // Flag the cycle after the last strobe of a frame as the comb cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_r <= 1'b0;
    end else begin
      dec_r <= pdm_stb && (cnt_r == CNT_MAX);
    end
  end

  // Comb differences on the frame-end I3 (i3_r still holds it during the comb
  // cycle even if a new strobe arrives), then clamp the all-ones case and scale.
  always_comb begin
    c1_s = i3_r - d1_r;
    c2_s = c1_s - d2_r;
    c3_s = c2_s - d3_r;
    if (c3_s[N-1]) begin
      sat_s = {(N-1){1'b1}};
    end else begin
      sat_s = c3_s[N-2:0];
    end
    word_s = WIDTH'(sat_s >> SHIFT);
  end

  // Comb delay registers and the registered output word / strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_r    <= {N{1'b0}};
      d2_r    <= {N{1'b0}};
      d3_r    <= {N{1'b0}};
      out_val <= {WIDTH{1'b0}};
      out_stb <= 1'b0;
    end else if (dec_r) begin
      d1_r    <= i3_r;
      d2_r    <= c1_s;
      d3_r    <= c2_s;
      out_val <= word_s;
      out_stb <= 1'b1;
    end else begin
      d1_r    <= d1_r;
      d2_r    <= d2_r;
      d3_r    <= d3_r;
      out_val <= out_val;
      out_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_rx.sv
// Testbench for pdm_rx (defaults: R = 64, WIDTH = 16). Table of periodic input
// patterns with expected settled words, plus directed latency/reset sequences.
module tb_pdm_rx;

  logic        clk;
  logic        rst;
  logic        pdm_in;
  logic        pdm_stb;
  logic [15:0] out_val;
  logic        out_stb;

  int n_pass;
  int n_total;
  int cyc;

  pdm_rx dut (
    .clk     (clk),
    .rst     (rst),
    .pdm_in  (pdm_in),
    .pdm_stb (pdm_stb),
    .out_val (out_val),
    .out_stb (out_stb)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;      // pat[0] is the first bit of the period
    int          len;
    int          div;      // strobe once every div cycles
    logic [15:0] exp_val;
    int          period;   // expected out_stb period in cycles
    int          first;    // first word that must be exact
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One-edge reset; afterwards the next edge is edge 1 of the new frame.
  task automatic do_reset();
    rst = 1'b1; pdm_in = 1'b0; pdm_stb = 1'b0;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Count edges until out_stb is seen (bounded); returns edge number or -1.
  task automatic wait_stb(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (out_stb) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int wv[5];
    int wc[5];
    int nw, idx, ph, at, changes;
    logic [15:0] held;
    n_pass = 0; n_total = 0; cyc = 0;
    rst = 1'b1; pdm_in = 1'b0; pdm_stb = 1'b0;

    vecs[0] = '{pat: 4'b0000, len: 1, div: 1, exp_val: 16'h0000, period: 64,  first: 1};
    vecs[1] = '{pat: 4'b0001, len: 1, div: 1, exp_val: 16'hFFFF, period: 64,  first: 3};
    vecs[2] = '{pat: 4'b0001, len: 2, div: 1, exp_val: 16'h8000, period: 64,  first: 3};
    vecs[3] = '{pat: 4'b0001, len: 4, div: 1, exp_val: 16'h4000, period: 64,  first: 3};
    vecs[4] = '{pat: 4'b0001, len: 2, div: 4, exp_val: 16'h8000, period: 256, first: 3};
    vecs[5] = '{pat: 4'b0001, len: 4, div: 4, exp_val: 16'h4000, period: 256, first: 3};
    vecs[6] = '{pat: 4'b0001, len: 1, div: 4, exp_val: 16'hFFFF, period: 256, first: 3};

    // Reset state.
    step(); step();
    chk("reset out_val", int'(out_val), 0);
    chk("reset out_stb", int'(out_stb), 0);

    // Table-driven pattern vectors.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      nw = 0; idx = 0; ph = 0;
      for (int c = 0; c < 5 * vecs[v].period + 400 && nw < 5; c++) begin
        pdm_in  = vecs[v].pat[idx % vecs[v].len];
        pdm_stb = (ph == vecs[v].div - 1);
        step();
        if (ph == vecs[v].div - 1) begin
          ph = 0;
          idx++;
        end else begin
          ph++;
        end
        if (out_stb) begin
          wv[nw] = int'(out_val);
          wc[nw] = cyc;
          nw++;
        end
      end
      chk($sformatf("vec%0d word count", v), nw, 5);
      for (int w = 0; w < nw; w++) begin
        if (w + 1 >= vecs[v].first)
          chk($sformatf("vec%0d word%0d", v, w + 1), wv[w], int'(vecs[v].exp_val));
        if (w > 0)
          chk($sformatf("vec%0d period%0d", v, w), wc[w] - wc[w-1], vecs[v].period);
      end
    end

    // Latency, pulse width and hold, constant 1 from reset.
    do_reset();
    pdm_in = 1'b1; pdm_stb = 1'b1;
    wait_stb(200, at);
    chk("first out_stb edge", at, 65);
    chk("word1 below full scale", int'(out_val < 16'hFFFF), 1);
    held = out_val;
    step();
    chk("out_stb one cycle", int'(out_stb), 0);
    changes = 0;
    for (int i = 0; i < 62; i++) begin
      if (out_val != held) changes++;
      if (out_stb) changes++;
      step();
    end
    chk("out_val held between words", changes, 0);
    wait_stb(10, at);
    chk("second out_stb edge", at, 129);

    // Reset 30 strobes into a frame with a nonzero word present.
    for (int i = 0; i < 30; i++) step();
    chk("word before reset nonzero", int'(out_val != 16'h0000), 1);
    rst = 1'b1;
    step();
    chk("mid reset out_val", int'(out_val), 0);
    chk("mid reset out_stb", int'(out_stb), 0);
    rst = 1'b0; cyc = 0;
    wait_stb(200, at);
    chk("out_stb after mid reset", at, 65);

    // Reset landing on the comb cycle cancels the pending word.
    do_reset();
    pdm_in = 1'b1; pdm_stb = 1'b1;
    for (int i = 0; i < 64; i++) step();
    rst = 1'b1;
    step();
    chk("pending word cancelled", int'(out_stb), 0);
    rst = 1'b0; cyc = 0;
    step();
    chk("no stray out_stb", int'(out_stb), 0);
    cyc = 0;
    pdm_stb = 1'b0;
    do_reset();
    pdm_stb = 1'b1;
    wait_stb(200, at);
    chk("out_stb after cancel", at, 65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
